product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter PROD_W, default 16, width of the incoming multiplier product.
REQ-002 SHALL have parameter ACC_W, default 24, width of the accumulator (ACC_W >= PROD_W).
REQ-003 SHALL have parameter LEN_W, default 8, width of the block-length field.
REQ-004 SHALL have port clk_i  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port start_i  input  1  one-cycle pulse that opens a new accumulation block.
REQ-007 SHALL have port len_i  input  LEN_W  number of products in the block; sampled on an accepted start_i.
REQ-008 SHALL have port prod_i  input  PROD_W  unsigned product from the 8x8 multiplier stage.
REQ-009 SHALL have port prod_valid_i  input  1  prod_i is valid this cycle.
REQ-010 SHALL have port clear_i  input  1  synchronous abort; returns to IDLE.
REQ-011 SHALL have port acc_o  output  ACC_W  accumulated sum.
REQ-012 SHALL have port acc_valid_o  output  1  one-cycle pulse: acc_o holds a completed block sum.
REQ-013 SHALL have port busy_o  output  1  high in ACC and DONE states.
REQ-014 SHALL have port ovf_o  output  1  sticky accumulator carry-out flag for the current block.

Function
REQ-015 SHALL implement the state machine IDLE -> ACC -> DONE -> IDLE.
REQ-016 In IDLE, start_i=1 SHALL latch len_i, zero acc_o, zero the product counter, clear ovf_o, and enter ACC; if len_i=0 it SHALL enter DONE instead.
REQ-017 start_i SHALL be ignored outside IDLE.
REQ-018 In ACC, each cycle with prod_valid_i=1 SHALL add zero-extended prod_i to acc_o and increment the counter; prod_valid_i=0 SHALL hold all state.
REQ-019 The cycle accepting the product that makes the count equal the latched length SHALL transition ACC -> DONE.
REQ-020 prod_valid_i SHALL be ignored in IDLE and DONE.
REQ-021 DONE SHALL last exactly one cycle with acc_valid_o=1, then return to IDLE.
REQ-022 acc_valid_o SHALL rise on the clock edge following the final accepted product (latency 1 cycle).
REQ-023 acc_o SHALL hold the block result from DONE until the next accepted start_i or clear_i.
REQ-024 Addition SHALL wrap modulo 2^ACC_W; any carry-out SHALL set ovf_o, which stays set until the next start, clear or reset.
REQ-025 clear_i=1 SHALL, in any state, force IDLE, zero acc_o, the counter and ovf_o, and suppress acc_valid_o; clear_i SHALL take priority over start_i and prod_valid_i in the same cycle.
REQ-026 busy_o SHALL be a registered decode of state, with no combinational path from inputs.

Reset
REQ-027 rst_i=1 SHALL immediately force state IDLE, acc_o=0, acc_valid_o=0, busy_o=0, ovf_o=0 and counter=0, independent of clk_i, including mid-block.
REQ-028 After rst_i deasserts, the first accepted start_i SHALL begin a clean block.

Structure
REQ-029 A shared package acc_pkg SHALL hold the state encoding (IDLE, ACC, DONE) and the default PROD_W/ACC_W/LEN_W constants.
REQ-030 The block SHALL be a single module with no sub-modules; it SHALL be instantiated in top fed by the multiplier product output.

Verification
REQ-031 start_i, len_i=3, products 10,20,30 on consecutive cycles -> acc_o=60, acc_valid_o one pulse the cycle after the third product, ovf_o=0.
REQ-032 len_i=3, products 5,7,9 with prod_valid_i low for 2 cycles between each -> acc_o=21, a single acc_valid_o pulse, busy_o high throughout.
REQ-033 len_i=0 -> DONE the cycle after start_i, acc_o=0, acc_valid_o one pulse.
REQ-034 len_i=255, every product 65025 -> acc_o=16581375 (0xFD02FF), ovf_o=0; with ACC_W=16, len_i=2, products 65025,65025 -> acc_o=64514, ovf_o=1.
REQ-035 clear_i asserted after 2 of 4 products -> IDLE next cycle, acc_o=0, no acc_valid_o; start_i and clear_i in the same cycle -> state stays IDLE.
REQ-036 rst_i pulsed asynchronously mid-ACC -> all outputs 0 immediately; a following len_i=1 block with product 100 -> acc_o=100.

Source files
------------

// File: rtl/acc_pkg.sv
// acc_pkg
// Shared definitions for the product accumulator: FSM state encoding and the
// default widths of the product, accumulator and block-length fields.
package acc_pkg;

    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } acc_state_t;

endpackage : acc_pkg

// File: rtl/product_accumulator.sv
// product_accumulator
// Sums a block of len_i unsigned multiplier products into a wrapping
// accumulator. The sum is reported with a one-cycle acc_valid_o pulse.
//
// Ports:
//   clk_i        in   1       system clock, rising edge
//   rst_i        in   1       asynchronous active-high reset
//   start_i      in   1       opens a new block (honoured in IDLE only)
//   len_i        in   LEN_W   products in the block, sampled with start_i
//   prod_i       in   PROD_W  unsigned product
//   prod_valid_i in   1       prod_i valid this cycle
//   clear_i      in   1       synchronous abort back to IDLE
//   acc_o        out  ACC_W   accumulated sum (held after a block completes)
//   acc_valid_o  out  1       one-cycle pulse: acc_o holds a completed sum
//   busy_o       out  1       high while in ACC or DONE
//   ovf_o        out  1       sticky carry-out for the current block
module product_accumulator
    import acc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              prod_valid_i,
    input  logic              clear_i,
    output logic [ACC_W-1:0]  acc_o,
    output logic              acc_valid_o,
    output logic              busy_o,
    output logic              ovf_o
);

    acc_state_t         r_state;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic               r_valid;
    logic               r_busy;

    acc_state_t         w_state_nxt;
    logic [LEN_W-1:0]   w_len_nxt;
    logic [LEN_W-1:0]   w_cnt_nxt;
    logic [LEN_W-1:0]   w_cnt_inc;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic               w_ovf_nxt;
    logic [ACC_W:0]     w_sum;

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_ovf_nxt   = r_ovf;
        // Extra top bit of the sum is the carry-out of the wrapping add.
        w_sum       = {1'b0, r_acc} + (ACC_W+1)'(prod_i);
        w_cnt_inc   = r_cnt + LEN_W'(1);

        if (clear_i) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_acc_nxt   = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        w_len_nxt   = len_i;
                        w_cnt_nxt   = '0;
                        w_acc_nxt   = '0;
                        w_ovf_nxt   = 1'b0;
                        w_state_nxt = (len_i == '0) ? ST_DONE : ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (prod_valid_i) begin
                        w_acc_nxt = w_sum[ACC_W-1:0];
                        w_ovf_nxt = r_ovf | w_sum[ACC_W];
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == r_len) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Status outputs are registered from the next-state decode so they track
    // the state register exactly, with no combinational input-to-output path.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
            r_ovf   <= w_ovf_nxt;
            r_valid <= (w_state_nxt == ST_DONE);
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign acc_o       = r_acc;
    assign acc_valid_o = r_valid;
    assign busy_o      = r_busy;
    assign ovf_o       = r_ovf;

endmodule : product_accumulator

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
// Directed and randomized blocks applied in parallel to a default-width
// accumulator (ACC_W=24) and a narrow one (ACC_W=16); expected sums and
// overflow flags come from the true running total of each block.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic [15:0] prod;
    logic        prod_valid;
    logic        clear;

    logic [23:0] acc24;
    logic        valid24, busy24, ovf24;
    logic [15:0] acc16;
    logic        valid16, busy16, ovf16;

    int checks = 0;
    int errors = 0;

    int unsigned     prods[$];
    int unsigned     gaps[$];
    longint unsigned tot;

    always #5 clk = ~clk;

    product_accumulator dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .len_i        (len),
        .prod_i       (prod),
        .prod_valid_i (prod_valid),
        .clear_i      (clear),
        .acc_o        (acc24),
        .acc_valid_o  (valid24),
        .busy_o       (busy24),
        .ovf_o        (ovf24)
    );

    product_accumulator #(
        .PROD_W (16),
        .ACC_W  (16),
        .LEN_W  (8)
    ) dut16 (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .len_i        (len),
        .prod_i       (prod),
        .prod_valid_i (prod_valid),
        .clear_i      (clear),
        .acc_o        (acc16),
        .acc_valid_o  (valid16),
        .busy_o       (busy16),
        .ovf_o        (ovf16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare both DUTs against the running true total of the current block.
    task automatic check_outs(input string tag, input logic exp_valid, input logic exp_busy);
        check({tag, " acc24"},   64'(acc24),   tot % 64'd16777216);
        check({tag, " ovf24"},   64'(ovf24),   64'(tot >= 64'd16777216));
        check({tag, " valid24"}, 64'(valid24), 64'(exp_valid));
        check({tag, " busy24"},  64'(busy24),  64'(exp_busy));
        check({tag, " acc16"},   64'(acc16),   tot % 64'd65536);
        check({tag, " ovf16"},   64'(ovf16),   64'(tot >= 64'd65536));
        check({tag, " valid16"}, 64'(valid16), 64'(exp_valid));
        check({tag, " busy16"},  64'(busy16),  64'(exp_busy));
    endtask

    // Runs one block from the prods/gaps queues (gaps[i] idle cycles precede
    // product i), then one idle cycle, then ignored products in IDLE.
    task automatic run_block(input string tag, input int unsigned n);
        start = 1'b1;
        len   = 8'(n);
        step();
        start = 1'b0;
        tot   = 0;
        if (n == 0) check_outs({tag, " len0 done"}, 1'b1, 1'b1);
        else        check_outs({tag, " started"}, 1'b0, 1'b1);
        for (int i = 0; i < int'(n); i++) begin
            for (int g = 0; g < int'(gaps[i]); g++) begin
                prod = 16'($urandom);
                step();
                check_outs({tag, " gap"}, 1'b0, 1'b1);
            end
            prod_valid = 1'b1;
            prod       = 16'(prods[i]);
            // start during ACC must be ignored
            start      = ($urandom_range(0, 3) == 0);
            step();
            prod_valid = 1'b0;
            start      = 1'b0;
            tot        = tot + longint'(prods[i]);
            check_outs({tag, " product"}, (i == int'(n) - 1), 1'b1);
        end
        prod_valid = 1'b1;
        prod       = 16'($urandom);
        step();
        check_outs({tag, " after done"}, 1'b0, 1'b0);
        step();
        prod_valid = 1'b0;
        check_outs({tag, " idle ignores prod"}, 1'b0, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        len        = '0;
        prod       = '0;
        prod_valid = 1'b0;
        clear      = 1'b0;
        tot        = 0;
        #2;
        check_outs("reset", 1'b0, 1'b0);
        step();
        #3 rst = 1'b0;
        step();
        check_outs("post reset idle", 1'b0, 1'b0);

        // 10,20,30 back to back
        prods = '{10, 20, 30};
        gaps  = '{0, 0, 0};
        run_block("b3", 3);

        // 5,7,9 with two idle cycles between products
        prods = '{5, 7, 9};
        gaps  = '{0, 2, 2};
        run_block("gapped", 3);

        // empty block
        prods = '{};
        gaps  = '{};
        run_block("len0", 0);

        // 255 maximal products: fits in 24 bits, wraps in 16 bits
        prods = '{};
        gaps  = '{};
        for (int i = 0; i < 255; i++) begin
            prods.push_back(65025);
            gaps.push_back(0);
        end
        run_block("len255", 255);

        // two maximal products: 64514 with carry in the 16-bit accumulator
        prods = '{65025, 65025};
        gaps  = '{0, 0};
        run_block("wrap16", 2);

        // clear after 2 of 4 products, with a product offered in the same cycle
        start = 1'b1;
        len   = 8'd4;
        step();
        start = 1'b0;
        tot   = 0;
        for (int i = 0; i < 2; i++) begin
            prod_valid = 1'b1;
            prod       = 16'd40000;
            step();
            tot = tot + 40000;
        end
        check_outs("pre clear", 1'b0, 1'b1);
        clear = 1'b1;
        prod  = 16'd123;
        step();
        clear      = 1'b0;
        prod_valid = 1'b0;
        tot        = 0;
        check_outs("clear", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_outs("after clear", 1'b0, 1'b0);
        end

        // start and clear together: stays IDLE
        start = 1'b1;
        clear = 1'b1;
        len   = 8'd2;
        step();
        start = 1'b0;
        clear = 1'b0;
        check_outs("start+clear", 1'b0, 1'b0);
        prod_valid = 1'b1;
        prod       = 16'd77;
        step();
        prod_valid = 1'b0;
        check_outs("start+clear idle", 1'b0, 1'b0);

        // asynchronous reset mid-block
        start = 1'b1;
        len   = 8'd5;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            prod_valid = 1'b1;
            prod       = 16'd999;
            step();
        end
        prod_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        tot = 0;
        check_outs("async reset", 1'b0, 1'b0);
        #2 rst = 1'b0;
        step();
        check_outs("after async reset", 1'b0, 1'b0);
        prods = '{100};
        gaps  = '{0};
        run_block("post reset block", 1);

        // randomized blocks
        for (int b = 0; b < 8; b++) begin
            int unsigned n;
            n     = $urandom_range(1, 8);
            prods = '{};
            gaps  = '{};
            for (int i = 0; i < int'(n); i++) begin
                prods.push_back($urandom_range(0, 65025));
                gaps.push_back($urandom_range(0, 2));
            end
            run_block("random", n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_product_accumulator
